// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: walks a WIDTH-input combinational block through every
// input vector, lets each settle, and records the output bit per vector.
module truth_table_sweeper #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               abort_i,
  output logic [WIDTH-1:0]   dut_a_o,
  input  logic               dut_z_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2**WIDTH-1:0] truth_table_o,
  output logic [WIDTH:0]     ones_count_o
);

  localparam int N  = 2**WIDTH;
  localparam int CW = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dut_a_q, dut_a_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [N-1:0]     tt_q, tt_d;
  logic [WIDTH:0]   ones_q, ones_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      dut_a_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tt_q    <= '0;
      ones_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      dut_a_q <= dut_a_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tt_q    <= tt_d;
      ones_q  <= ones_d;
    end
  end

  // Abort outranks a coinciding sample edge, so an aborted sweep never
  // records the vector that was in flight.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    dut_a_d = dut_a_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    tt_d    = tt_q;
    ones_d  = ones_q;

    case (state_q)
      IDLE: begin
        dut_a_d = '0;
        busy_d  = 1'b0;
        if (start_i && !abort_i) begin
          state_d = RUN;
          idx_d   = '0;
          cnt_d   = CW'(SETTLE);
          busy_d  = 1'b1;
          tt_d    = '0;
          ones_d  = '0;
        end
      end

      RUN: begin
        if (abort_i) begin
          state_d = IDLE;
          dut_a_d = '0;
          busy_d  = 1'b0;
        end else if (cnt_q > CW'(1)) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          tt_d[idx_q] = dut_z_i;
          ones_d      = ones_q + {{WIDTH{1'b0}}, dut_z_i};
          if (idx_q == WIDTH'(N - 1)) begin
            state_d = DONE;
            dut_a_d = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + WIDTH'(1);
            dut_a_d = idx_q + WIDTH'(1);
            cnt_d   = CW'(SETTLE);
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        dut_a_d = '0;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        dut_a_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign dut_a_o       = dut_a_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign truth_table_o = tt_q;
  assign ones_count_o  = ones_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (SETTLE=2 and SETTLE=1) sweep a
// behavioural model block whose truth table is chosen per scenario.
module tb_truth_table_sweeper;

  localparam int WIDTH = 4;
  localparam int N     = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, start, abort;
  logic [WIDTH-1:0] dutA0, dutA1;
  logic             dutZ0, dutZ1;
  logic             busy0, busy1, done0, done1;
  logic [N-1:0]     tt0, tt1;
  logic [WIDTH:0]   ones0, ones1;

  logic [N-1:0]     modelTable;
  int               checks = 0;
  int               passes = 0;
  int               doneSeen0 = 0;
  int               doneSeen1 = 0;

  assign dutZ0 = modelTable[dutA0];
  assign dutZ1 = modelTable[dutA1];

  truth_table_sweeper #(.WIDTH(WIDTH), .SETTLE(2)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
    .dut_a_o(dutA0), .dut_z_i(dutZ0), .busy_o(busy0), .done_o(done0),
    .truth_table_o(tt0), .ones_count_o(ones0)
  );

  truth_table_sweeper #(.WIDTH(WIDTH), .SETTLE(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
    .dut_a_o(dutA1), .dut_z_i(dutZ1), .busy_o(busy1), .done_o(done1),
    .truth_table_o(tt1), .ones_count_o(ones1)
  );

  always @(negedge clk) begin
    if (done0 === 1'b1) doneSeen0++;
    if (done1 === 1'b1) doneSeen1++;
  end

  function automatic bit isPrime(input int a);
    if (a < 2) return 1'b0;
    for (int d = 2; d * d <= a; d++)
      if (a % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic setPrime();
    for (int a = 0; a < N; a++) modelTable[a] = isPrime(a);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the caller 1 time unit after the edge that accepted start.
  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic waitDone0(input int limit);
    int n = 0;
    while (done0 !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    checks++;
    if (done0 !== 1'b1) $display("[TB] FAIL done_timeout: done0=%b after %0d clks, required 1", done0, n);
    else passes++;
  endtask

  task automatic test_reset();
    int base;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    tick(); tick();
    rst = 1'b0;
    checks++; if ({dutA0, busy0, done0, tt0, ones0} !== '0) $display("[TB] FAIL reset_init: a=%h busy=%b done=%b tt=%h ones=%0d, required all 0", dutA0, busy0, done0, tt0, ones0); else passes++;

    setPrime();
    pulseStart();
    repeat (10) tick();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++; if ({dutA0, busy0, done0, tt0, ones0} !== '0) $display("[TB] FAIL reset_mid0: a=%h busy=%b done=%b tt=%h ones=%0d, required all 0", dutA0, busy0, done0, tt0, ones0); else passes++;
    checks++; if ({dutA1, busy1, done1, tt1, ones1} !== '0) $display("[TB] FAIL reset_mid1: a=%h busy=%b done=%b tt=%h ones=%0d, required all 0", dutA1, busy1, done1, tt1, ones1); else passes++;
    base = doneSeen0;
    repeat (40) tick();
    checks++; if (doneSeen0 !== base) $display("[TB] FAIL reset_no_done: done pulses=%0d, required 0", doneSeen0 - base); else passes++;
  endtask

  task automatic test_prime();
    setPrime();
    pulseStart();
    for (int k = 0; k < 2 * N; k++) begin
      checks++;
      if (dutA0 !== WIDTH'(k / 2) || busy0 !== 1'b1 || done0 !== 1'b0)
        $display("[TB] FAIL prime_step%0d: a=%0d busy=%b done=%b, required a=%0d busy=1 done=0", k, dutA0, busy0, done0, k / 2);
      else passes++;
      tick();
    end
    checks++; if (done0 !== 1'b1 || busy0 !== 1'b0 || dutA0 !== '0) $display("[TB] FAIL prime_done: done=%b busy=%b a=%0d, required 1 0 0", done0, busy0, dutA0); else passes++;
    checks++; if (tt0 !== 16'h28AC) $display("[TB] FAIL prime_table: got %h, required 28ac", tt0); else passes++;
    checks++; if (ones0 !== 5'd6) $display("[TB] FAIL prime_ones: got %0d, required 6", ones0); else passes++;
    tick();
    checks++; if (done0 !== 1'b0 || tt0 !== 16'h28AC) $display("[TB] FAIL prime_after: done=%b tt=%h, required 0 28ac", done0, tt0); else passes++;
    repeat (4) tick();
  endtask

  task automatic test_constant();
    for (int v = 0; v < 2; v++) begin
      modelTable = (v == 1) ? 16'hFFFF : 16'h0000;
      pulseStart();
      waitDone0(100);
      checks++; if (tt0 !== ((v == 1) ? 16'hFFFF : 16'h0000)) $display("[TB] FAIL const%0d_table: got %h", v, tt0); else passes++;
      checks++; if (ones0 !== ((v == 1) ? 5'd16 : 5'd0)) $display("[TB] FAIL const%0d_ones: got %0d, required %0d", v, ones0, v * 16); else passes++;
      repeat (4) tick();
    end
  endtask

  task automatic test_abort();
    int base;
    logic [N-1:0] partial;
    modelTable = 16'($urandom);
    pulseStart();
    repeat (9) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    // Samples land on edges 2,4,6,8 after start, so vectors 0..3 were recorded.
    partial = modelTable & 16'h000F;
    checks++; if (busy0 !== 1'b0 || dutA0 !== '0 || done0 !== 1'b0) $display("[TB] FAIL abort_state: busy=%b a=%0d done=%b, required 0 0 0", busy0, dutA0, done0); else passes++;
    base = doneSeen0;
    repeat (40) tick();
    checks++; if (doneSeen0 !== base) $display("[TB] FAIL abort_no_done: pulses=%0d, required 0", doneSeen0 - base); else passes++;
    checks++; if (tt0 !== partial) $display("[TB] FAIL abort_partial: got %h, required %h", tt0, partial); else passes++;
    checks++; if (ones0 !== 5'($countones(partial))) $display("[TB] FAIL abort_ones: got %0d, required %0d", ones0, $countones(partial)); else passes++;
    pulseStart();
    waitDone0(100);
    checks++; if (tt0 !== modelTable) $display("[TB] FAIL abort_rerun: got %h, required %h", tt0, modelTable); else passes++;
    repeat (4) tick();
  endtask

  task automatic test_back_to_back();
    int base;
    setPrime();
    base = doneSeen0;
    pulseStart();
    repeat (5) tick();
    start = 1'b1; tick(); start = 1'b0;
    repeat (10) tick();
    start = 1'b1; tick(); start = 1'b0;
    waitDone0(100);
    start = 1'b1; tick(); start = 1'b0;
    repeat (3) tick();
    checks++; if (busy0 !== 1'b0) $display("[TB] FAIL b2b_done_start: busy=%b, required 0", busy0); else passes++;
    repeat (40) tick();
    checks++; if (doneSeen0 - base !== 1) $display("[TB] FAIL b2b_pulses: got %0d, required 1", doneSeen0 - base); else passes++;
    checks++; if (tt0 !== 16'h28AC) $display("[TB] FAIL b2b_table: got %h, required 28ac", tt0); else passes++;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    checks++; if (busy0 !== 1'b0 || busy1 !== 1'b0) $display("[TB] FAIL start_abort_idle: busy0=%b busy1=%b, required 0 0", busy0, busy1); else passes++;
    repeat (3) tick();
    checks++; if (tt0 !== 16'h28AC || busy0 !== 1'b0) $display("[TB] FAIL start_abort_hold: tt=%h busy=%b, required 28ac 0", tt0, busy0); else passes++;
  endtask

  task automatic test_settle1();
    setPrime();
    pulseStart();
    for (int k = 0; k < N; k++) begin
      checks++;
      if (dutA1 !== WIDTH'(k) || done1 !== 1'b0) $display("[TB] FAIL s1_step%0d: a=%0d done=%b, required a=%0d done=0", k, dutA1, done1, k);
      else passes++;
      tick();
    end
    checks++; if (done1 !== 1'b1) $display("[TB] FAIL s1_done: done=%b, required 1", done1); else passes++;
    checks++; if (tt1 !== 16'h28AC || ones1 !== 5'd6) $display("[TB] FAIL s1_table: tt=%h ones=%0d, required 28ac 6", tt1, ones1); else passes++;
    waitDone0(100);
    repeat (4) tick();
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      modelTable = 16'($urandom);
      pulseStart();
      waitDone0(100);
      checks++; if (tt0 !== modelTable) $display("[TB] FAIL rand%0d_table: got %h, required %h", r, tt0, modelTable); else passes++;
      checks++; if (ones0 !== 5'($countones(modelTable))) $display("[TB] FAIL rand%0d_ones: got %0d, required %0d", r, ones0, $countones(modelTable)); else passes++;
      checks++; if (tt1 !== modelTable) $display("[TB] FAIL rand%0d_table_s1: got %h, required %h", r, tt1, modelTable); else passes++;
      repeat (4) tick();
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    modelTable = '0;
    test_reset();
    test_prime();
    test_constant();
    test_abort();
    test_back_to_back();
    test_settle1();
    test_random();
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
